// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   - uart_state_t     : receiver state encoding (IDLE, START, DATA, PARITY, STOP)
//   - CNT_W            : width of the per-bit clock counter
//   - calc_clks_per_bit: system clocks per line bit, integer division
//   - calc_half_bit    : clocks from the start-bit edge to the middle of the start bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int CNT_W = 16;

  // clk_mhz is in MHz, so scale it up to Hz before dividing by the baud rate.
  function automatic int calc_clks_per_bit(input int clk_mhz, input int baud);
    return (clk_mhz * 1_000_000) / baud;
  endfunction

  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for bringing asynchronous signals
// into the clk domain. Both stages reset synchronously to 0.
//   clk   in          : destination clock
//   rst   in          : synchronous active-high reset
//   d     in  [WIDTH] : asynchronous input
//   q     out [WIDTH] : synchronized output (2 cycles of latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with a
// valid/ready holding register and framing / overrun / parity reporting.
//   clk           in      : system clock
//   rst           in      : synchronous active-high reset
//   rx            in      : asynchronous serial line, idles high
//   rx_ready      in      : consumer accepts the held byte
//   rx_data       out [8] : held byte
//   rx_valid      out     : held byte is valid
//   rx_busy       out     : receiver is inside a frame (state not IDLE)
//   rx_frame_err  out     : one-cycle pulse, stop bit sampled low
//   rx_overrun    out     : one-cycle pulse, unaccepted byte overwritten
//   rx_parity_err out     : one-cycle pulse, even-parity mismatch (0 without macro)
// Build option: define UART_RX_PARITY_EN to add the even-parity bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 27,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_parity_err
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = calc_half_bit(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic             synced;
  logic             prev_reg;
  uart_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       rx_data_reg;
  logic             rx_valid_reg;
  logic             frame_err_reg;
  logic             overrun_reg;
  logic             parity_bad;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (synced)
  );

  // prev resets to 0, so a line held low across reset release never looks
  // like a falling edge.
  logic fall;
  logic at_bit_end;
  logic stop_sample;
  logic commit;

  assign fall        = prev_reg & ~synced;
  assign at_bit_end  = (cnt_reg == BIT_LAST);
  assign stop_sample = (state_reg == STOP) && at_bit_end;
  assign commit      = stop_sample && synced && !parity_bad;

`ifdef UART_RX_PARITY_EN
  logic parity_bad_reg;
  logic parity_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bad_reg <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      parity_err_reg <= stop_sample && parity_bad_reg;
      if (state_reg == DATA) begin
        parity_bad_reg <= 1'b0;
      end else if (state_reg == PARITY && at_bit_end) begin
        // Even parity: the parity bit makes the total count of ones even.
        parity_bad_reg <= (synced != ^shift_reg);
      end
    end
  end

  assign parity_bad    = parity_bad_reg;
  assign rx_parity_err = parity_err_reg;
`else
  assign parity_bad    = 1'b0;
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg      <= 1'b0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      prev_reg      <= synced;
      frame_err_reg <= stop_sample && !synced;
      overrun_reg   <= 1'b0;

      // Holding register: a commit always wins; an accept in the same cycle
      // just means the old byte was consumed, so there is no overrun.
      if (commit) begin
        rx_data_reg  <= shift_reg;
        rx_valid_reg <= 1'b1;
        overrun_reg  <= rx_valid_reg && !rx_ready;
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (fall) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end

        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (!synced) begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
            end else begin
              // Line went back high before mid-start: a glitch, not a frame.
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (at_bit_end) begin
            cnt_reg   <= '0;
            shift_reg <= {synced, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_bit_end) begin
            cnt_reg   <= '0;
            state_reg <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          // Leave at mid-stop so a following start edge is caught on time.
          if (at_bit_end) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign rx_busy      = (state_reg != IDLE);
  assign rx_frame_err = frame_err_reg;
  assign rx_overrun   = overrun_reg;

endmodule
